fast_multimode_sampler: RTL and testbench
=========================================

// Module: fast_multimode_sampler
// PURPOSE
// - Elastic, mode-selectable FAST circle sampler for the feature extractor. Sits between the 7x7 window builder and the FAST comparators.
// - Maps one 7x7 window per beat to a centre pixel plus a FAST-16, FAST-12 or FAST-8 circle.
// - Tracks the centre-pixel (x,y) position and flags windows whose circle would cross the image border.
// - Adds valid/ready backpressure, which the fixed FAST-16 sampler does not have.
// PARAMETERS
// - DATA_WIDTH  8     pixel width
// - IMG_WIDTH   640   pixels per line (centre positions)
// - IMG_HEIGHT  480   lines per frame
// - X_W/Y_W     $clog2(IMG_WIDTH)/$clog2(IMG_HEIGHT); localparams, not overridable
// PORTS
// - clk            in   1                 clock
// - rst_n          in   1                 async active-low reset
// - in_valid       in   1                 window beat valid
// - in_ready       out  1                 sampler accepts beat
// - in_sof         in   1                 beat is first centre of frame
// - in_eol         in   1                 beat is last centre of line
// - in_mode        in   2                 0=FAST16 r3, 1=FAST12 r2, 2=FAST8 r1, 3=rsvd
// - window         in   DW x [0:6][0:6]   row0 newest, centre [3][3]
// - out_valid      out  1                 sample valid
// - out_ready      in   1                 downstream accepts
// - center_pixel   out  DW                window[3][3]
// - circle_pixel   out  DW x [0:15]       circle, clockwise from top; unused slots 0
// - circle_len     out  5                 16/12/8
// - out_x,out_y    out  X_W,Y_W           centre coordinate
// - out_border     out  1                 circle not fully inside image, or unsynced
// - err_line_len   out  1                 sticky: line exceeded IMG_WIDTH without eol
// - err_mode       out  1                 sticky: mode 3 latched
// BEHAVIOUR
// - Reset: all outputs 0, in_ready=1, FSM=UNSYNC, x=y=0, latched mode=FAST16.
// - Pipeline: 2 stages (S1 window reg, S2 mapped output reg). Latency 2 cycles from accept to out_valid with out_ready=1.
// - Throughput: 1 beat/cycle.
// - Handshake:
//   - s2_free = !out_valid | out_ready; in_ready = !s1_valid | s2_free.
//   - Transfer occurs on valid&ready. Outputs hold stable while out_valid & !out_ready. No beat is dropped or duplicated.
// - Mode:
//   - Sampled only on an accepted beat with in_sof=1; that beat uses the new mode. Ignored otherwise.
//   - Mode 3 maps as FAST16 and sets err_mode.
//   - Both errs clear on the next accepted sof.
// - Patterns (row,col), index 0 at top, clockwise:
//   - FAST16: (0,3)(0,4)(1,5)(2,6)(3,6)(4,6)(5,5)(6,4)(6,3)(6,2)(5,1)(4,0)(3,0)(2,0)(1,1)(0,2)
//   - FAST12: (1,3)(1,4)(2,5)(3,5)(4,5)(5,4)(5,3)(5,2)(4,1)(3,1)(2,1)(1,2)
//   - FAST8:  (2,3)(2,4)(3,4)(4,4)(4,3)(4,2)(3,2)(2,2)
// - FSM UNSYNC/ACTIVE:
//   - An accepted sof enters ACTIVE with x=y=0 from any state, even mid-line.
//   - In UNSYNC, beats pass through with out_border=1 and x=y=0.
// - Counters (ACTIVE, per accepted beat):
//   - eol: x<=0, y<=y+1. An eol with y=IMG_HEIGHT-1 returns the FSM to UNSYNC.
//   - Without eol: x<=x+1. At x=IMG_WIDTH-1, x saturates and err_line_len sets.
//   - sof+eol on the same beat: sof restarts, then eol applies, giving next x=0, y=1.
// - Border: R=3/2/1 by latched mode. out_border = x<R | x>IMG_WIDTH-1-R | y<R | y>IMG_HEIGHT-1-R.
// - Coordinates, border flag and mode travel with the beat through both stages.
// - Reset mid-frame: in-flight beats discarded; out_valid drops asynchronously.
// STRUCTURE
// - fast_pkg: fast_mode_e enum, localparam pattern tables (row,col per mode), circle_len and radius functions.
// - Sub-module fast_circle_mux: combinational, window+mode -> centre/circle/len. Instanced between S1 and S2.
// - The top level holds the FSM, counters, handshake and sticky errors.
// TESTING
// - Use window[r][c]=16r+c throughout.
// 1. FAST16 sof beat, out_ready=1:
//    - out_valid at cycle+2, center=0x33, circle[0]=0x03, [4]=0x36, [15]=0x02, len=16.
// 2. mode=1 then 2 on sof beats:
//    - FAST12 gives circle[0]=0x13, [11]=0x12, [12..15]=0, len=12.
//    - FAST8 gives [0]=0x23, [7]=0x22, [8..15]=0.
// 3. 20 beats in a row, out_ready low for cycles 3-8:
//    - in_ready falls within 2 cycles and no beat is lost.
//    - Outputs hold stable and the output order matches the input order.
// 4. IMG 16x8, FAST16 frame:
//    - out_border=1 for x in {0-2,13-15} or y in {0-2,5-7}. (4,4) gives 0. Post-last-eol beat gives UNSYNC, border=1.
// 5. 17 beats with no eol at IMG_WIDTH=16:
//    - x saturates at 15 and err_line_len=1. Next sof clears it.
//    - mode=3 gives a FAST16 map with err_mode=1.
// 6. Assert rst_n mid-stream with out_valid=1:
//    - out_valid=0 immediately. After release, a beat without sof gives border=1, x=y=0.

Source files
------------

// File: rtl/fast_pkg.sv
// rtl/fast_pkg.sv - FAST circle sampler modes, pattern tables and mode helpers
package fast_pkg;

  typedef enum logic [1:0] {
    MODE_FAST16 = 2'd0,
    MODE_FAST12 = 2'd1,
    MODE_FAST8  = 2'd2,
    MODE_RSVD   = 2'd3
  } fast_mode_e;

  // (row,col) of each circle tap inside the 7x7 window, index 0 at top, clockwise
  localparam logic [0:15][2:0] P16_ROW = {3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
                                          3'd6, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [0:15][2:0] P16_COL = {3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd6, 3'd5, 3'd4,
                                          3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2};
  localparam logic [0:11][2:0] P12_ROW = {3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                                          3'd5, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [0:11][2:0] P12_COL = {3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd4,
                                          3'd3, 3'd2, 3'd1, 3'd1, 3'd1, 3'd2};
  localparam logic [0:7][2:0]  P8_ROW  = {3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd3, 3'd2};
  localparam logic [0:7][2:0]  P8_COL  = {3'd3, 3'd4, 3'd4, 3'd4, 3'd3, 3'd2, 3'd2, 3'd2};

  function automatic logic [4:0] mode_circle_len(input fast_mode_e m);
    case (m)
      MODE_FAST12: mode_circle_len = 5'd12;
      MODE_FAST8:  mode_circle_len = 5'd8;
      default:     mode_circle_len = 5'd16;
    endcase
  endfunction

  function automatic logic [1:0] mode_radius(input fast_mode_e m);
    case (m)
      MODE_FAST12: mode_radius = 2'd2;
      MODE_FAST8:  mode_radius = 2'd1;
      default:     mode_radius = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/fast_circle_mux.sv
// rtl/fast_circle_mux.sv - combinational window-to-circle mapping for one FAST mode
module fast_circle_mux
  import fast_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [0:6][0:6][DATA_WIDTH-1:0] window,
  input  fast_mode_e                      mode,
  output logic [DATA_WIDTH-1:0]           center_pixel,
  output logic [0:15][DATA_WIDTH-1:0]     circle_pixel,
  output logic [4:0]                      circle_len
);

  always_comb begin
    center_pixel = window[3][3];
    circle_pixel = '0;
    circle_len   = mode_circle_len(mode);
    case (mode)
      MODE_FAST12: begin
        for (int i = 0; i < 12; i++) circle_pixel[i] = window[P12_ROW[i]][P12_COL[i]];
      end
      MODE_FAST8: begin
        for (int i = 0; i < 8; i++) circle_pixel[i] = window[P8_ROW[i]][P8_COL[i]];
      end
      // reserved mode falls back to the full FAST-16 circle
      default: begin
        for (int i = 0; i < 16; i++) circle_pixel[i] = window[P16_ROW[i]][P16_COL[i]];
      end
    endcase
  end

endmodule

// File: rtl/fast_multimode_sampler.sv
// rtl/fast_multimode_sampler.sv - elastic two-stage FAST sampler with position tracking and border flag
module fast_multimode_sampler
  import fast_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  localparam int X_W = $clog2(IMG_WIDTH),
  localparam int Y_W = $clog2(IMG_HEIGHT)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_sof,
  input  logic                            in_eol,
  input  logic [1:0]                      in_mode,
  input  logic [0:6][0:6][DATA_WIDTH-1:0] window,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           center_pixel,
  output logic [0:15][DATA_WIDTH-1:0]     circle_pixel,
  output logic [4:0]                      circle_len,
  output logic [X_W-1:0]                  out_x,
  output logic [Y_W-1:0]                  out_y,
  output logic                            out_border,
  output logic                            err_line_len,
  output logic                            err_mode
);

  typedef enum logic {ST_UNSYNC, ST_ACTIVE} state_e;

  state_e     state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  fast_mode_e mode_q, mode_d;
  logic       err_line_len_q, err_line_len_d;
  logic       err_mode_q, err_mode_d;

  logic                            s1_valid_q, s1_valid_d;
  logic [0:6][0:6][DATA_WIDTH-1:0] s1_window_q, s1_window_d;
  fast_mode_e                      s1_mode_q, s1_mode_d;
  logic [X_W-1:0]                  s1_x_q, s1_x_d;
  logic [Y_W-1:0]                  s1_y_q, s1_y_d;
  logic                            s1_border_q, s1_border_d;

  logic                        out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]       center_pixel_q, center_pixel_d;
  logic [0:15][DATA_WIDTH-1:0] circle_pixel_q, circle_pixel_d;
  logic [4:0]                  circle_len_q, circle_len_d;
  logic [X_W-1:0]              out_x_q, out_x_d;
  logic [Y_W-1:0]              out_y_q, out_y_d;
  logic                        out_border_q, out_border_d;

  logic [DATA_WIDTH-1:0]       mux_center;
  logic [0:15][DATA_WIDTH-1:0] mux_circle;
  logic [4:0]                  mux_len;

  logic           s2_free, accept, beat_active, beat_border;
  fast_mode_e     beat_mode;
  logic [X_W-1:0] beat_x;
  logic [Y_W-1:0] beat_y;
  int             bx, by, br;

  fast_circle_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux (
    .window       (s1_window_q),
    .mode         (s1_mode_q),
    .center_pixel (mux_center),
    .circle_pixel (mux_circle),
    .circle_len   (mux_len)
  );

  assign s2_free = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept = in_valid && in_ready;

  // A sof beat is its own frame origin and uses its own mode, whatever the current state
  always_comb begin
    beat_mode   = in_sof ? fast_mode_e'(in_mode) : mode_q;
    beat_active = in_sof || (state_q == ST_ACTIVE);
    beat_x      = in_sof ? '0 : x_q;
    beat_y      = in_sof ? '0 : y_q;
    bx          = int'(beat_x);
    by          = int'(beat_y);
    br          = int'(mode_radius(beat_mode));
    beat_border = !beat_active || (bx < br) || (bx > IMG_WIDTH - 1 - br) ||
                  (by < br) || (by > IMG_HEIGHT - 1 - br);
  end

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    mode_d         = mode_q;
    err_line_len_d = err_line_len_q;
    err_mode_d     = err_mode_q;
    if (accept) begin
      if (in_sof) begin
        mode_d         = fast_mode_e'(in_mode);
        err_mode_d     = (in_mode == 2'd3);
        err_line_len_d = 1'b0;
      end
      if (beat_active) begin
        if (in_eol) begin
          x_d = '0;
          if (by == IMG_HEIGHT - 1) begin
            state_d = ST_UNSYNC;
            y_d     = '0;
          end else begin
            state_d = ST_ACTIVE;
            y_d     = beat_y + 1'b1;
          end
        end else begin
          state_d = ST_ACTIVE;
          y_d     = beat_y;
          if (bx == IMG_WIDTH - 1) begin
            x_d            = beat_x;
            err_line_len_d = 1'b1;
          end else begin
            x_d = beat_x + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_window_d = s1_window_q;
    s1_mode_d   = s1_mode_q;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_border_d = s1_border_q;
    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_window_d = window;
      s1_mode_d   = beat_mode;
      s1_x_d      = beat_x;
      s1_y_d      = beat_y;
      s1_border_d = beat_border;
    end else if (s2_free) begin
      s1_valid_d = 1'b0;
    end

    out_valid_d    = out_valid_q;
    center_pixel_d = center_pixel_q;
    circle_pixel_d = circle_pixel_q;
    circle_len_d   = circle_len_q;
    out_x_d        = out_x_q;
    out_y_d        = out_y_q;
    out_border_d   = out_border_q;
    if (s2_free) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        center_pixel_d = mux_center;
        circle_pixel_d = mux_circle;
        circle_len_d   = mux_len;
        out_x_d        = s1_x_q;
        out_y_d        = s1_y_q;
        out_border_d   = s1_border_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_UNSYNC;
      x_q            <= '0;
      y_q            <= '0;
      mode_q         <= MODE_FAST16;
      err_line_len_q <= 1'b0;
      err_mode_q     <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_window_q    <= '0;
      s1_mode_q      <= MODE_FAST16;
      s1_x_q         <= '0;
      s1_y_q         <= '0;
      s1_border_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      center_pixel_q <= '0;
      circle_pixel_q <= '0;
      circle_len_q   <= '0;
      out_x_q        <= '0;
      out_y_q        <= '0;
      out_border_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      mode_q         <= mode_d;
      err_line_len_q <= err_line_len_d;
      err_mode_q     <= err_mode_d;
      s1_valid_q     <= s1_valid_d;
      s1_window_q    <= s1_window_d;
      s1_mode_q      <= s1_mode_d;
      s1_x_q         <= s1_x_d;
      s1_y_q         <= s1_y_d;
      s1_border_q    <= s1_border_d;
      out_valid_q    <= out_valid_d;
      center_pixel_q <= center_pixel_d;
      circle_pixel_q <= circle_pixel_d;
      circle_len_q   <= circle_len_d;
      out_x_q        <= out_x_d;
      out_y_q        <= out_y_d;
      out_border_q   <= out_border_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign center_pixel = center_pixel_q;
  assign circle_pixel = circle_pixel_q;
  assign circle_len   = circle_len_q;
  assign out_x        = out_x_q;
  assign out_y        = out_y_q;
  assign out_border   = out_border_q;
  assign err_line_len = err_line_len_q;
  assign err_mode     = err_mode_q;

endmodule

// File: tb/tb_fast_multimode_sampler.sv
// tb/tb_fast_multimode_sampler.sv - scoreboard bench for fast_multimode_sampler on a 16x8 image
module tb_fast_multimode_sampler;

  localparam int W = 16;
  localparam int H = 8;

  localparam logic [0:15][7:0] EXP16 = {8'h03, 8'h04, 8'h15, 8'h26, 8'h36, 8'h46, 8'h55, 8'h64,
                                        8'h63, 8'h62, 8'h51, 8'h40, 8'h30, 8'h20, 8'h11, 8'h02};
  localparam logic [0:15][7:0] EXP12 = {8'h13, 8'h14, 8'h25, 8'h35, 8'h45, 8'h54, 8'h53, 8'h52,
                                        8'h41, 8'h31, 8'h21, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [0:15][7:0] EXP8  = {8'h23, 8'h24, 8'h34, 8'h44, 8'h43, 8'h42, 8'h32, 8'h22,
                                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, in_sof, in_eol;
  logic [1:0] in_mode;
  logic [0:6][0:6][7:0] window;
  logic out_valid, out_ready;
  logic [7:0] center_pixel;
  logic [0:15][7:0] circle_pixel;
  logic [4:0] circle_len;
  logic [3:0] out_x;
  logic [2:0] out_y;
  logic out_border, err_line_len, err_mode;

  always #5 clk = ~clk;

  fast_multimode_sampler #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_eol(in_eol), .in_mode(in_mode), .window(window), .out_valid(out_valid),
    .out_ready(out_ready), .center_pixel(center_pixel), .circle_pixel(circle_pixel),
    .circle_len(circle_len), .out_x(out_x), .out_y(out_y), .out_border(out_border),
    .err_line_len(err_line_len), .err_mode(err_mode)
  );

  typedef struct packed {
    logic [7:0]       center;
    logic [0:15][7:0] circ;
    logic [4:0]       len;
    logic [3:0]       x;
    logic [2:0]       y;
    logic             border;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_exp, mon_got, hold_snap;
  logic hold_pend = 1'b0;
  int checks = 0;
  int failures = 0;
  int count_en = 0;
  int zero_cnt = 0;

  int m_active, m_x, m_y;
  logic [1:0] m_mode;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_x = 0; m_y = 0; m_mode = 2'd0;
    sbq.delete();
  endtask

  task automatic model_accept(input logic sof, input logic eol, input logic [1:0] mode);
    exp_t e;
    int r;
    if (sof) begin
      m_mode = mode; m_active = 1; m_x = 0; m_y = 0;
    end
    case (m_mode)
      2'd1:    begin e.circ = EXP12; e.len = 5'd12; r = 2; end
      2'd2:    begin e.circ = EXP8;  e.len = 5'd8;  r = 1; end
      default: begin e.circ = EXP16; e.len = 5'd16; r = 3; end
    endcase
    e.center = 8'h33;
    e.x = 4'(m_x);
    e.y = 3'(m_y);
    e.border = (m_active == 0) || (m_x < r) || (m_x > W - 1 - r) || (m_y < r) || (m_y > H - 1 - r);
    sbq.push_back(e);
    if (m_active != 0) begin
      if (eol) begin
        m_x = 0;
        if (m_y == H - 1) begin m_active = 0; m_y = 0; end
        else m_y = m_y + 1;
      end else if (m_x < W - 1) begin
        m_x = m_x + 1;
      end
    end
  endtask

  task automatic send(input logic sof, input logic eol, input logic [1:0] mode);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1; in_sof = sof; in_eol = eol; in_mode = mode;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        model_accept(sof, eol, mode);
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout got=no_accept expected=accept");
    end
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 300) begin
      failures++;
      $display("FAIL drain_timeout got=%0d_pending expected=0", sbq.size());
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      mon_got.center = center_pixel;
      mon_got.circ   = circle_pixel;
      mon_got.len    = circle_len;
      mon_got.x      = out_x;
      mon_got.y      = out_y;
      mon_got.border = out_border;
      if (hold_pend && out_valid) begin
        checks++;
        if (mon_got !== hold_snap) begin
          failures++;
          $display("FAIL hold got=%h expected=%h", mon_got, hold_snap);
        end
      end
      hold_pend = 1'b0;
      if (out_valid && out_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat got x=%0d y=%0d expected=none", out_x, out_y);
        end else begin
          mon_exp = sbq.pop_front();
          if (mon_got !== mon_exp) begin
            failures++;
            $display("FAIL beat got c=%h circ=%h len=%0d x=%0d y=%0d b=%0d expected c=%h circ=%h len=%0d x=%0d y=%0d b=%0d",
                     mon_got.center, mon_got.circ, mon_got.len, mon_got.x, mon_got.y, mon_got.border,
                     mon_exp.center, mon_exp.circ, mon_exp.len, mon_exp.x, mon_exp.y, mon_exp.border);
          end
        end
        if (count_en != 0 && !out_border) zero_cnt++;
      end else if (out_valid && !out_ready) begin
        hold_pend = 1'b1;
        hold_snap = mon_got;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        window[r][c] = 8'(16 * r + c);
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; in_mode = 2'd0; out_ready = 1'b1;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_border", out_border, 0);
    chk("rst_len", circle_len, 0);
    chk("rst_errs", {err_line_len, err_mode}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: FAST16 latency and taps
    send(1, 0, 2'd0);
    @(negedge clk); chk("t1_lat_s1", out_valid, 0);
    @(negedge clk); chk("t1_lat_s2", out_valid, 1);
    chk("t1_center", center_pixel, 8'h33);
    chk("t1_c0", circle_pixel[0], 8'h03);
    chk("t1_c4", circle_pixel[4], 8'h36);
    chk("t1_c15", circle_pixel[15], 8'h02);
    chk("t1_len", circle_len, 16);
    drain();

    // 2: FAST12, mode ignored off-sof, FAST8, then sof+eol on one beat
    send(1, 0, 2'd1);
    send(0, 0, 2'd2);
    send(1, 0, 2'd2);
    send(1, 1, 2'd0);
    send(0, 0, 2'd0);
    drain();

    // 3: back-to-back stream with downstream stall
    fork
      begin
        for (int i = 0; i < 20; i++) send(i == 0, i == 9, 2'd0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t3_in_ready_low", in_ready, 0);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("t3_none_lost", sbq.size(), 0);

    // 4: full 16x8 frame, then a beat after the last eol
    zero_cnt = 0;
    count_en = 1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        send(x == 0 && y == 0, x == W - 1, 2'd0);
    send(0, 0, 2'd0);
    drain();
    count_en = 0;
    chk("t4_interior_count", zero_cnt, 20);

    // 5: line overrun, then reserved mode
    send(1, 0, 2'd0);
    for (int i = 0; i < 16; i++) send(0, 0, 2'd0);
    drain();
    chk("t5_err_line", err_line_len, 1);
    chk("t5_err_mode_clear", err_mode, 0);
    send(1, 0, 2'd3);
    chk("t5_err_line_cleared", err_line_len, 0);
    chk("t5_err_mode_set", err_mode, 1);
    drain();
    send(1, 0, 2'd0);
    chk("t5_err_mode_cleared", err_mode, 0);
    drain();

    // 6: reset while holding a valid output
    out_ready = 1'b0;
    send(1, 0, 2'd1);
    send(0, 0, 2'd1);
    chk("t6_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_drop", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(0, 0, 2'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
